// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcodes, the bubble word and the fetch-stage state type.
package wisc_pkg;

  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // ADD r0,r0,r0: the decoder suppresses the write to r0, so this is a true no-op.
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  function automatic logic is_hlt(input logic [3:0] opcode);
    return opcode == OP_HLT;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response handshake between the fetch stage and imem.
interface fetch_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;

  modport master (output imem_req, output imem_addr, input imem_rdy, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_rdy, output imem_data);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, and neither means hold.
module if_id_reg #(
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_plus2_in,
  output logic [15:0] instr,
  output logic [15:0] pc_plus2,
  output logic        valid
);

  logic [15:0] instr_reg;
  logic [15:0] pc_plus2_reg;
  logic        valid_reg;

  // A bubble carries pc_plus2 = 0, the same value the register wakes up with.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      instr_reg    <= NOP_INSTR;
      pc_plus2_reg <= 16'h0000;
      valid_reg    <= 1'b0;
    end else if (load) begin
      instr_reg    <= instr_in;
      pc_plus2_reg <= pc_plus2_in;
      valid_reg    <= 1'b1;
    end
  end

  assign instr    = instr_reg;
  assign pc_plus2 = pc_plus2_reg;
  assign valid    = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// WISC instruction-fetch stage: PC, imem handshake, stall hold buffer, redirect and HLT.
// Optional FETCH_WAIT_CNT_EN adds a saturating count of cycles spent waiting on imem.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = wisc_pkg::NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_stage_if.master        imem,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [15:0]          redirect_pc,
  output logic [15:0]          if_id_instr,
  output logic [15:0]          if_id_pc_plus2,
  output logic                 if_id_valid,
  output logic [15:0]          pc,
  output logic                 halted
`ifdef FETCH_WAIT_CNT_EN
  ,
  output logic [15:0]          fetch_wait_cnt
`endif
);

  import wisc_pkg::*;

  fetch_state_t state_reg, state_next;
  logic [15:0]  pc_reg, pc_next;
  logic [15:0]  kill_addr_reg, kill_addr_next;
  logic [15:0]  hold_instr_reg, hold_instr_next;
  logic [15:0]  hold_pc2_reg, hold_pc2_next;
  logic         req_reg, req_next;
  logic         halted_reg, halted_next;

  logic         ifid_load, ifid_flush;
  logic [15:0]  ifid_instr_in, ifid_pc2_in;
  logic         accept;
  logic [15:0]  pc_plus2;
  logic [15:0]  addr_out;
  logic         redirect_pc_unused;

  assign redirect_pc_unused = redirect_pc[0];
  assign accept   = req_reg & imem.imem_rdy;
  assign pc_plus2 = pc_reg + 16'd2;
  // While a stale request drains, the address must stay where it was issued.
  assign addr_out = (state_reg == KILL) ? kill_addr_reg : pc_reg;

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    kill_addr_next  = kill_addr_reg;
    hold_instr_next = hold_instr_reg;
    hold_pc2_next   = hold_pc2_reg;
    halted_next     = halted_reg;
    ifid_load       = 1'b0;
    ifid_flush      = 1'b0;
    ifid_instr_in   = imem.imem_data;
    ifid_pc2_in     = pc_plus2;

    if (redirect) begin
      pc_next         = {redirect_pc[15:1], 1'b0};
      ifid_flush      = 1'b1;
      hold_instr_next = NOP_INSTR;
      hold_pc2_next   = 16'h0000;
      halted_next     = 1'b0;
      kill_addr_next  = addr_out;
      state_next      = (req_reg && !imem.imem_rdy) ? KILL : FETCH;
    end else begin
      case (state_reg)
        FETCH: begin
          if (accept) begin
            if (!is_hlt(imem.imem_data[15:12])) pc_next = pc_plus2;
            if (stall) begin
              hold_instr_next = imem.imem_data;
              hold_pc2_next   = pc_plus2;
              state_next      = HOLD;
            end else begin
              ifid_load = 1'b1;
              if (is_hlt(imem.imem_data[15:12])) begin
                state_next  = HALT;
                halted_next = 1'b1;
              end
            end
          end else if (!stall) begin
            ifid_flush = 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_load       = 1'b1;
            ifid_instr_in   = hold_instr_reg;
            ifid_pc2_in     = hold_pc2_reg;
            hold_instr_next = NOP_INSTR;
            hold_pc2_next   = 16'h0000;
            if (is_hlt(hold_instr_reg[15:12])) begin
              state_next  = HALT;
              halted_next = 1'b1;
            end else begin
              state_next = FETCH;
            end
          end
        end
        KILL: begin
          if (!stall) ifid_flush = 1'b1;
          if (accept) state_next = FETCH;
        end
        HALT: begin
          state_next = HALT;
        end
        default: state_next = FETCH;
      endcase
    end

    req_next = (state_next == FETCH) || (state_next == KILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= FETCH;
      pc_reg         <= {RESET_PC[15:1], 1'b0};
      kill_addr_reg  <= 16'h0000;
      hold_instr_reg <= NOP_INSTR;
      hold_pc2_reg   <= 16'h0000;
      req_reg        <= 1'b0;
      halted_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      kill_addr_reg  <= kill_addr_next;
      hold_instr_reg <= hold_instr_next;
      hold_pc2_reg   <= hold_pc2_next;
      req_reg        <= req_next;
      halted_reg     <= halted_next;
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk         (clk),
    .rst         (rst),
    .load        (ifid_load),
    .flush       (ifid_flush),
    .instr_in    (ifid_instr_in),
    .pc_plus2_in (ifid_pc2_in),
    .instr       (if_id_instr),
    .pc_plus2    (if_id_pc_plus2),
    .valid       (if_id_valid)
  );

  assign imem.imem_req  = req_reg;
  assign imem.imem_addr = {addr_out[15:1], 1'b0};
  assign pc             = pc_reg;
  assign halted         = halted_reg;

`ifdef FETCH_WAIT_CNT_EN
  logic [15:0] wait_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_reg <= 16'h0000;
    end else if (req_reg && !imem.imem_rdy && (wait_cnt_reg != 16'hFFFF)) begin
      wait_cnt_reg <= wait_cnt_reg + 16'd1;
    end
  end

  assign fetch_wait_cnt = wait_cnt_reg;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit WISC pipeline, directly upstream of the decoder.
- Owns the PC and drives the instruction-memory request handshake.
- Fills the IF/ID pipeline register that the decoder reads; honours hazard stalls, branch redirects and HLT.
- One outstanding memory request at a time; the PC advances by 2 per accepted instruction.

Parameters:
- RESET_PC, 16'h0000, PC value after reset.
- NOP_INSTR, 16'h0000, bubble word: ADD to r0, so the decoder asserts no write enable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held high with a stable imem_addr until imem_rdy.
- imem_addr  out  16  fetch address; bit 0 is always 0.
- imem_rdy  in  1  imem_data is valid this cycle; completes the request.
- imem_data  in  16  fetched instruction word.
- stall  in  1  hazard unit: hold the IF/ID contents.
- redirect  in  1  taken B/BR resolved downstream: flush and load a new PC.
- redirect_pc  in  16  target PC; bit 0 is ignored and forced to 0.
- if_id_instr  out  16  instruction to the decoder.
- if_id_pc_plus2  out  16  fetch address + 2, used by branch and PCS.
- if_id_valid  out  1  if_id_instr is a real instruction, not a bubble.
- pc  out  16  address of the next instruction to fetch.
- halted  out  1  HLT has entered IF/ID; fetching has stopped.

Behaviour:
- Reset values (rst high at a clock edge):
  - pc=RESET_PC, state=FETCH.
  - if_id_instr=NOP_INSTR, if_id_pc_plus2=0, if_id_valid=0.
  - imem_req=0 in the reset cycle; halted=0; hold buffer empty.
- rst has priority over every other input. Reset in the middle of a request drops it; its response is never used, and imem_req may fall without waiting for imem_rdy.
- States: FETCH, HOLD, KILL, HALT.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_rdy & !stall: IF/ID <= {imem_data, pc+2, valid=1}; pc <= pc+2. Zero added latency, so data is seen by the decoder the cycle after rdy.
  - On imem_rdy & stall: IF/ID holds; the word and pc+2 go to the hold buffer; pc <= pc+2; next state HOLD.
  - If the accepted word has opcode 4'hF: next state HALT, and pc is not incremented.
- HOLD:
  - imem_req=0.
  - When stall drops: the buffer moves into IF/ID; next state is FETCH, or HALT if the buffered word is HLT.
- KILL:
  - imem_req stays high with the old address until imem_rdy.
  - The response is discarded; next state FETCH, at the redirected pc.
- HALT:
  - imem_req=0, halted=1; IF/ID holds HLT (after a stall it still loads once when stall drops).
  - Only redirect or rst leaves HALT.
- redirect (highest priority after rst, in every state, including during stall):
  - pc <= {redirect_pc[15:1],1'b0}.
  - IF/ID <= NOP_INSTR with valid=0; the hold buffer is cleared.
  - If a request is in flight without imem_rdy this cycle: next state KILL, else FETCH.
  - redirect while imem_rdy=1: the word arriving that cycle is discarded.
- stall with no redirect: IF/ID and if_id_valid are unchanged, even when the register holds a bubble.
- PC arithmetic is modulo 2^16: 16'hFFFE + 2 = 16'h0000, with no flag.

Optional Feature:
- Macro: FETCH_WAIT_CNT_EN.
- With the macro defined:
  - Adds output port fetch_wait_cnt [15:0].
  - Counts cycles with imem_req & !imem_rdy; saturates at 16'hFFFF.
  - Reset to 0 by rst; not cleared by redirect.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package (wisc_pkg):
  - OP_HLT=4'hF, OP_B=4'hC, OP_BR=4'hD, OP_SW=4'h9, OP_PCS=4'hE.
  - NOP_INSTR value.
  - Fetch state enum {FETCH, HOLD, KILL, HALT}.
- Sub-module if_id_reg: IF/ID register with load, hold and flush controls.
- PC logic, hold buffer and FSM stay in fetch_stage.

Test Plan:
- rst, then imem_rdy=1 every cycle with words 16'h1234, 16'h2345 -> imem_addr 0,2; IF/ID gets 16'h1234/pc_plus2=2, then 16'h2345/4; pc=4.
- imem_rdy delayed 3 cycles -> imem_req and imem_addr=0 stable for 4 cycles; IF/ID loads once; fetch_wait_cnt=3 with the macro.
- stall=1 for 2 cycles while rdy returns 16'hABCD at addr 6 -> IF/ID unchanged during the stall; 16'hABCD with pc_plus2=8 appears the cycle after stall drops; pc=8.
- redirect with redirect_pc=16'h0041 while a request is pending -> pc=16'h0040, if_id_valid=0, stale response discarded, next imem_addr=16'h0040.
- Fetch 16'hF000 at addr 10 -> halted=1, imem_req=0, pc stays 10; a later redirect to 16'h0020 clears halted and resumes fetch at 16'h0020.
- pc=16'hFFFE accepted word -> pc wraps to 16'h0000, if_id_pc_plus2=16'h0000; rst mid-request -> all outputs at reset values next cycle.
